irq_controller: RTL

- Bus-mapped interrupt controller between up to 8 peripheral interrupt sources (timer, mouse, switches, etc.) and the processor's two interrupt lines.
- Captures source rising edges into a pending register and applies a mask.
- Routes each source to processor line 0 or 1, and presents one source at a time per line using fixed priority.
- Clears the presented source when the processor acknowledges it, and exposes mask, pending, route and cause registers on the shared 8-bit bus.

---
 rtl/irq_ctrl_pkg.sv | 37 +++
 rtl/irq_line_fsm.sv | 66 ++++++
 rtl/irq_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
//  Module   : irq_ctrl_pkg
//  Brief    : Shared constants, line FSM encoding and priority helper for the
//             interrupt controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

    localparam logic [2:0] OFS_MASK    = 3'd0;
    localparam logic [2:0] OFS_PENDING = 3'd1;
    localparam logic [2:0] OFS_ROUTE   = 3'd2;
    localparam logic [2:0] OFS_CAUSE0  = 3'd3;
    localparam logic [2:0] OFS_CAUSE1  = 3'd4;

    localparam logic [7:0] NO_CAUSE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAISE = 2'd1,
        GAP   = 2'd2
    } line_state_e;

    // Index of the lowest set bit; lowest index is highest priority.
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_line_fsm.sv
// ============================================================================
//  Module   : irq_line_fsm
//  Brief    : Per-line presentation FSM: latches the winning candidate, holds
//             the request until acknowledged, then idles for one gap cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_line_fsm
    import irq_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] cand_i,
    input  logic       ack_i,
    output logic       raise_o,
    output logic [7:0] cause_o,
    output logic       clr_o,
    output logic [2:0] clr_idx_o
);

    line_state_e state_q, state_d;
    logic [7:0]  cause_q, cause_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cause_q <= NO_CAUSE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Once in RAISE the cause is committed: candidate changes are ignored
    // until the acknowledge arrives.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        clr_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|cand_i) begin
                    cause_d = {5'd0, lowest_set(cand_i)};
                    state_d = RAISE;
                end
            end
            RAISE: begin
                if (ack_i) begin
                    clr_o   = 1'b1;
                    cause_d = NO_CAUSE;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign raise_o   = (state_q == RAISE);
    assign cause_o   = cause_q;
    assign clr_idx_o = cause_q[2:0];

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
//  Module   : irq_controller
//  Brief    : Bus-mapped interrupt controller: edge capture, mask, routing to
//             two processor lines and fixed-priority presentation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int         NUM_SRC   = 8,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    output logic [1:0]         BUS_INTERRUPTS_RAISE,
    input  logic [1:0]         BUS_INTERRUPTS_ACK
);

    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] route_q, route_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_en_q, rd_en_d;

    logic [7:0]         w_ofs;
    logic               w_hit, w_wr, w_rd;
    logic [NUM_SRC-1:0] w_edge, w_w1c, w_ack_clr;
    logic [7:0]         w_pend8, w_mask8, w_route8;
    logic [7:0]         w_cand    [2];
    logic [7:0]         w_cause   [2];
    logic [2:0]         w_clr_idx [2];
    logic [1:0]         w_clr;

    assign w_ofs  = BUS_ADDR - BASE_ADDR;
    assign w_hit  = (w_ofs <= 8'd4);
    assign w_wr   = w_hit & BUS_WE;
    assign w_rd   = w_hit & ~BUS_WE;
    assign w_edge = IRQ_IN & ~irq_q;

    // The history register follows the inputs even during reset, so a level
    // already high when reset is released is not seen as a fresh event.
    always_ff @(posedge CLK) begin
        irq_q <= IRQ_IN;
    end

    always_comb begin
        w_pend8  = 8'd0;
        w_mask8  = 8'd0;
        w_route8 = 8'd0;
        w_pend8[NUM_SRC-1:0]  = pending_q;
        w_mask8[NUM_SRC-1:0]  = mask_q;
        w_route8[NUM_SRC-1:0] = route_q;
    end

    assign w_cand[0] = w_pend8 & w_mask8 & ~w_route8;
    assign w_cand[1] = w_pend8 & w_mask8 &  w_route8;

    generate
        for (genvar l = 0; l < 2; l++) begin : g_line
            irq_line_fsm u_fsm (
                .clk_i     (CLK),
                .rst_i     (RESET),
                .cand_i    (w_cand[l]),
                .ack_i     (BUS_INTERRUPTS_ACK[l]),
                .raise_o   (BUS_INTERRUPTS_RAISE[l]),
                .cause_o   (w_cause[l]),
                .clr_o     (w_clr[l]),
                .clr_idx_o (w_clr_idx[l])
            );
        end
    endgenerate

    always_comb begin
        w_ack_clr = '0;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_clr[l] && (w_clr_idx[l] == 3'(i))) w_ack_clr[i] = 1'b1;
            end
        end
    end

    assign w_w1c = (w_wr && (w_ofs[2:0] == OFS_PENDING)) ? BUS_DATA[NUM_SRC-1:0] : '0;

    always_comb begin
        mask_d    = mask_q;
        route_d   = route_q;
        // A new edge outranks any clear landing on the same cycle.
        pending_d = (pending_q & ~w_w1c & ~w_ack_clr) | w_edge;
        if (w_wr) begin
            case (w_ofs[2:0])
                OFS_MASK:  mask_d  = BUS_DATA[NUM_SRC-1:0];
                OFS_ROUTE: route_d = BUS_DATA[NUM_SRC-1:0];
                default:   ;
            endcase
        end
        rd_en_d = w_rd;
        case (w_ofs[2:0])
            OFS_MASK:    rd_data_d = w_mask8;
            OFS_PENDING: rd_data_d = w_pend8;
            OFS_ROUTE:   rd_data_d = w_route8;
            OFS_CAUSE0:  rd_data_d = w_cause[0];
            OFS_CAUSE1:  rd_data_d = w_cause[1];
            default:     rd_data_d = 8'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_q <= '0;
            mask_q    <= '0;
            route_q   <= '0;
            rd_data_q <= 8'd0;
            rd_en_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            route_q   <= route_d;
            rd_data_q <= rd_data_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign BUS_DATA = rd_en_q ? rd_data_q : 8'bz;

endmodule

`default_nettype wire
